// File: rtl/act_lut_pkg.sv
// Shared activation-LUT parameters and loader state enumeration.
// With ACT_LUT_CHECKSUM_EN defined the CHECK state exists for the checksum beat.
package act_lut_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int ENTRIES = 2 ** ADDR_W;

`ifdef ACT_LUT_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } lut_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd3
  } lut_state_t;
`endif

endpackage

// File: rtl/act_lut_loader_if.sv
// Valid/ready load stream carrying table entries (and the optional checksum beat).
interface act_lut_loader_if #(
  parameter int DATA_W = act_lut_pkg::DATA_W
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/act_lut_regfile.sv
// ENTRIES x DATA_W table: one synchronous write port, two combinational reads, async clear.
module act_lut_regfile #(
  parameter int DATA_W = act_lut_pkg::DATA_W,
  parameter int ADDR_W = act_lut_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/act_lut_loader.sv
// Streams ENTRIES signed beats into the activation LUT and serves base/next lookups.
// Define ACT_LUT_CHECKSUM_EN to require a trailing mod-2**DATA_W checksum beat (adds load_err).
module act_lut_loader #(
  parameter int DATA_W = act_lut_pkg::DATA_W,
  parameter int ADDR_W = act_lut_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  act_lut_loader_if.slave          ld,
  input  logic [ADDR_W-1:0]        address,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] next_data,
  output logic                     busy,
`ifdef ACT_LUT_CHECKSUM_EN
  output logic                     load_err,
`endif
  output logic                     table_valid
);
  import act_lut_pkg::*;

  lut_state_t        state, next_state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] rd_base, rd_next;
  logic              accept;
  logic              last_entry;
  logic              wr_en;

  assign busy        = (state != IDLE) && (state != DONE);
  assign ld.in_ready = busy;
  assign accept      = ld.in_valid && ld.in_ready;
  assign last_entry  = &index;
  assign table_valid = (state == DONE);
  // start wins over a coincident beat, so the beat must not reach the table
  assign wr_en       = (state == LOAD) && accept && !start;

`ifdef ACT_LUT_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
  logic              sum_ok;
  assign sum_ok = (ld.in_data == acc);
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = IDLE;
      LOAD: begin
        if (accept && last_entry) begin
`ifdef ACT_LUT_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef ACT_LUT_CHECKSUM_EN
      CHECK: if (accept) next_state = sum_ok ? DONE : IDLE;
`endif
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
    if (start) next_state = LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= next_state;
      if (start)      index <= '0;
      else if (wr_en) index <= index + ADDR_W'(1);
    end
  end

`ifdef ACT_LUT_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      load_err <= 1'b0;
    end else if (start) begin
      acc      <= '0;
      load_err <= 1'b0;
    end else if (wr_en) begin
      acc <= acc + ld.in_data;
    end else if ((state == CHECK) && accept && !sum_ok) begin
      load_err <= 1'b1;
    end
  end
`endif

  // The last entry has no successor, so next_data repeats it.
  assign next_addr = last_addr(address) ? address : address + ADDR_W'(1);

  function automatic logic last_addr(input logic [ADDR_W-1:0] a);
    return &a;
  endfunction

  act_lut_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .waddr   (index),
    .wdata   (ld.in_data),
    .raddr_a (address),
    .rdata_a (rd_base),
    .raddr_b (next_addr),
    .rdata_b (rd_next)
  );

  assign base      = table_valid ? rd_base : '0;
  assign next_data = table_valid ? rd_next : '0;

endmodule

// File: tb/tb_act_lut_loader.sv
// Self-checking bench for act_lut_loader against a table-level reference model.
// Checksum scenarios run only when ACT_LUT_CHECKSUM_EN is defined.
module tb_act_lut_loader;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        address;
  logic signed [7:0] base, next_data;
  logic              busy, table_valid;
`ifdef ACT_LUT_CHECKSUM_EN
  logic              load_err;
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [7:0] model [16];
  bit         model_valid;
  logic [7:0] beats [16];
  logic [7:0] exp_b, exp_n;

  act_lut_loader_if #(.DATA_W(8)) ld_if ();

  act_lut_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ld          (ld_if),
    .address     (address),
    .base        (base),
    .next_data   (next_data),
    .busy        (busy),
`ifdef ACT_LUT_CHECKSUM_EN
    .load_err    (load_err),
`endif
    .table_valid (table_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_sum(input logic [7:0] d [16]);
    int s = 0;
    for (int i = 0; i < 16; i++) s += d[i];
    return 8'(s % 256);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    ld_if.in_valid = 1'b1;
    ld_if.in_data  = d;
    @(posedge clk); #1;
    ld_if.in_valid = 1'b0;
  endtask

  // Sends the checksum beat when the checksum feature is built in.
  task automatic finish_load(input logic [7:0] sum);
    if (CK) beat(sum);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; address = '0;
    ld_if.in_valid = 1'b0; ld_if.in_data = '0;
    model_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (table_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", table_valid); end
    ld_if.in_valid = 1'b1; ld_if.in_data = 8'h5a;
    @(posedge clk); #1;
    total++; if (ld_if.in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b want=0", ld_if.in_ready); end
    ld_if.in_valid = 1'b0;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); #1;
      total++; if (base !== 8'h00 || next_data !== 8'h00) begin
        bad++; $display("FAIL preload_lookup a=%0d got=%h/%h want=00/00", a, base, next_data);
      end
    end
  endtask

  task automatic test_ramp_load();
    for (int i = 0; i < 16; i++) beats[i] = 8'(i * 8);
    pulse_start();
    for (int i = 0; i < 15; i++) beat(beats[i]);
    total++; if (table_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL ramp_before_last valid=%b busy=%b want 0/1", table_valid, busy);
    end
    beat(beats[15]);
    total++; if (table_valid !== !CK) begin
      bad++; $display("FAIL ramp_valid_after_16 got=%b want=%b", table_valid, !CK);
    end
    finish_load(byte_sum(beats));
    for (int i = 0; i < 16; i++) model[i] = beats[i];
    model_valid = 1'b1;
    total++; if (table_valid !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ramp_done valid=%b busy=%b want 1/0", table_valid, busy);
    end
    address = 4'd3; #1;
    total++; if (base !== 8'h18 || next_data !== 8'h20) begin
      bad++; $display("FAIL ramp_addr3 got=%h/%h want=18/20", base, next_data);
    end
    address = 4'd15; #1;
    total++; if (base !== 8'h78 || next_data !== 8'h78) begin
      bad++; $display("FAIL ramp_addr15 got=%h/%h want=78/78", base, next_data);
    end
  endtask

  task automatic test_done_ignores_input();
    for (int k = 0; k < 4; k++) begin
      ld_if.in_valid = 1'b1; ld_if.in_data = 8'($urandom);
      @(posedge clk); #1;
      total++; if (ld_if.in_ready !== 1'b0) begin bad++; $display("FAIL done_ready got=%b want=0", ld_if.in_ready); end
    end
    ld_if.in_valid = 1'b0;
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); #1;
      exp_b = model[a]; exp_n = model[(a == 15) ? 15 : a + 1];
      total++; if (base !== exp_b || next_data !== exp_n) begin
        bad++; $display("FAIL done_lookup a=%0d got=%h/%h want=%h/%h", a, base, next_data, exp_b, exp_n);
      end
    end
  endtask

  task automatic test_bubbles();
    int idx = 0;
    int cyc = 0;
    bit v;
    for (int i = 0; i < 16; i++) beats[i] = 8'($urandom);
    pulse_start();
    while (idx < 16 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      ld_if.in_valid = v;
      ld_if.in_data  = v ? beats[idx] : 8'($urandom);
      @(posedge clk); #1;
      cyc++;
      if (v) idx++;
      if (idx < 16) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bubble_busy idx=%0d got=%b want=1", idx, busy); end
      end
    end
    ld_if.in_valid = 1'b0;
    total++; if (idx != 16) begin bad++; $display("FAIL bubble_timeout beats=%0d want=16", idx); end
    finish_load(byte_sum(beats));
    for (int i = 0; i < 16; i++) model[i] = beats[i];
    total++; if (table_valid !== 1'b1) begin bad++; $display("FAIL bubble_valid got=%b want=1", table_valid); end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); #1;
      exp_b = model[a]; exp_n = model[(a == 15) ? 15 : a + 1];
      total++; if (base !== exp_b || next_data !== exp_n) begin
        bad++; $display("FAIL bubble_lookup a=%0d got=%h/%h want=%h/%h", a, base, next_data, exp_b, exp_n);
      end
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    for (int i = 0; i < 7; i++) beat(8'($urandom));
    #2 rst = 1'b1;
    #1;
    model_valid = 1'b0;
    total++; if (busy !== 1'b0 || ld_if.in_ready !== 1'b0 || table_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_async busy=%b ready=%b valid=%b want 0/0/0", busy, ld_if.in_ready, table_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) beats[i] = 8'h01;
    pulse_start();
    for (int i = 0; i < 16; i++) beat(beats[i]);
    finish_load(byte_sum(beats));
    for (int i = 0; i < 16; i++) model[i] = beats[i];
    model_valid = 1'b1;
    total++; if (table_valid !== 1'b1) begin bad++; $display("FAIL reload_valid got=%b want=1", table_valid); end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); #1;
      total++; if (base !== model[a]) begin
        bad++; $display("FAIL reload_base a=%0d got=%h want=%h", a, base, model[a]);
      end
    end
  endtask

  task automatic test_start_collision();
    pulse_start();
    for (int i = 0; i < 9; i++) beat(8'($urandom));
    start = 1'b1; ld_if.in_valid = 1'b1; ld_if.in_data = 8'h7f;
    @(posedge clk); #1;
    start = 1'b0; ld_if.in_valid = 1'b0;
    total++; if (table_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL collide_restart valid=%b busy=%b want 0/1", table_valid, busy);
    end
    for (int i = 0; i < 16; i++) beats[i] = 8'(8'h40 + i);
    for (int i = 0; i < 15; i++) beat(beats[i]);
    total++; if (table_valid !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL collide_15_beats valid=%b busy=%b want 0/1", table_valid, busy);
    end
    beat(beats[15]);
    finish_load(byte_sum(beats));
    for (int i = 0; i < 16; i++) model[i] = beats[i];
    total++; if (table_valid !== 1'b1) begin bad++; $display("FAIL collide_valid got=%b want=1", table_valid); end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a); #1;
      exp_b = model[a]; exp_n = model[(a == 15) ? 15 : a + 1];
      total++; if (base !== exp_b || next_data !== exp_n) begin
        bad++; $display("FAIL collide_lookup a=%0d got=%h/%h want=%h/%h", a, base, next_data, exp_b, exp_n);
      end
    end
  endtask

`ifdef ACT_LUT_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start();
    for (int i = 0; i < 16; i++) beat(8'h10);
    beat(8'h00);
    total++; if (table_valid !== 1'b1 || load_err !== 1'b0) begin
      bad++; $display("FAIL cksum_match valid=%b err=%b want 1/0", table_valid, load_err);
    end
    pulse_start();
    for (int i = 0; i < 16; i++) beat(8'h10);
    beat(8'h01);
    total++; if (load_err !== 1'b1 || table_valid !== 1'b0 || busy !== 1'b0 || ld_if.in_ready !== 1'b0) begin
      bad++; $display("FAIL cksum_mismatch err=%b valid=%b busy=%b ready=%b want 1/0/0/0", load_err, table_valid, busy, ld_if.in_ready);
    end
    address = 4'd5; #1;
    total++; if (base !== 8'h00) begin bad++; $display("FAIL cksum_base_gated got=%h want=00", base); end
    repeat (2) @(posedge clk); #1;
    total++; if (load_err !== 1'b1) begin bad++; $display("FAIL cksum_sticky got=%b want=1", load_err); end
    pulse_start();
    total++; if (load_err !== 1'b0) begin bad++; $display("FAIL cksum_start_clear got=%b want=0", load_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp_load();
    test_done_ignores_input();
    test_bubbles();
    test_reset_midload();
    test_start_collision();
`ifdef ACT_LUT_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
